// File: rtl/vga_camera_emulator.sv
// Source model of the camera's parallel video port: pclk, v_sync, h_ref and YUV422 bytes.
// Define CAM_EMU_SCROLL_EN to add a per-frame counter that scrolls the luma ramp.
module vga_camera_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic       enable,
  output logic       pclk,
  output logic       v_sync,
  output logic       h_ref,
  output logic [7:0] data_out,
  output logic       frame_done
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int V_M1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
  localparam int BX_W  = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int LY_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [BX_W-1:0] BX_LAST = BX_W'(LINE - 1);
  localparam logic [BX_W-1:0] BX_HREF = BX_W'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  state_t            state, state_nx;
  logic [BX_W-1:0]   bx, bx_nx;
  logic [LY_W-1:0]   ly, ly_nx, ly_end;
  logic              tick;
  logic              frame_end;
  logic              v_sync_nx, h_ref_nx;
  logic [7:0]        data_nx, luma, ofs;

  // pclk is about to fall on this edge, so the video bus advances now
  assign tick = pclk;

`ifdef CAM_EMU_SCROLL_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      frame_cnt <= 8'h00;
    end else if (tick && frame_end) begin
      frame_cnt <= frame_cnt + 8'h01;
    end
  end

  assign ofs = frame_cnt;
`else
  assign ofs = 8'h00;
`endif

  always_comb begin
    ly_end    = '0;
    state_nx  = state;
    bx_nx     = bx;
    ly_nx     = ly;
    frame_end = 1'b0;
    case (state)
      VSYNC:   ly_end = LY_W'(V_SYNC - 1);
      VBACK:   ly_end = LY_W'(V_BACK - 1);
      ACTIVE:  ly_end = LY_W'(V_ACTIVE - 1);
      VFRONT:  ly_end = LY_W'(V_FRONT - 1);
      default: ly_end = '0;
    endcase

    if (state == IDLE) begin
      if (enable) begin
        state_nx = VSYNC;
        bx_nx    = '0;
        ly_nx    = '0;
      end
    end else if (bx == BX_LAST) begin
      bx_nx = '0;
      if (ly == ly_end) begin
        ly_nx = '0;
        case (state)
          VSYNC:   state_nx = VBACK;
          VBACK:   state_nx = ACTIVE;
          ACTIVE:  state_nx = VFRONT;
          VFRONT: begin
            frame_end = 1'b1;
            state_nx  = enable ? VSYNC : IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end else begin
        ly_nx = ly + LY_W'(1);
      end
    end else begin
      bx_nx = bx + BX_W'(1);
    end

    // Outputs are decoded from the position being entered so they register cleanly
    v_sync_nx = (state_nx == VSYNC);
    h_ref_nx  = (state_nx == ACTIVE) && (bx_nx < BX_HREF);
    luma      = 8'(bx_nx >> 1) + 8'(ly_nx) + ofs;
    data_nx   = 8'h00;
    if (h_ref_nx) begin
      data_nx = bx_nx[0] ? luma : 8'h80;
    end
  end

  // Register file for position, state and the registered video outputs
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      pclk       <= 1'b0;
      state      <= IDLE;
      bx         <= '0;
      ly         <= '0;
      v_sync     <= 1'b0;
      h_ref      <= 1'b0;
      data_out   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      if (tick) begin
        state      <= state_nx;
        bx         <= bx_nx;
        ly         <= ly_nx;
        v_sync     <= v_sync_nx;
        h_ref      <= h_ref_nx;
        data_out   <= data_nx;
        frame_done <= frame_end;
      end
    end
  end

endmodule

// File: tb/tb_vga_camera_emulator.sv
// Scoreboard bench for vga_camera_emulator with small frame parameters (LINE=10, 50 ticks/frame).
// Expected bus values are queued per clk_25 cycle and compared by a negedge monitor.
module tb_vga_camera_emulator;

  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 2;
  localparam int V_SYNC   = 1;
  localparam int V_BACK   = 1;
  localparam int V_ACTIVE = 2;
  localparam int V_FRONT  = 1;

`ifdef CAM_EMU_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  localparam logic [7:0] T_RST  = 8'd0;
  localparam logic [7:0] T_IDLE = 8'd1;
  localparam logic [7:0] T_A    = 8'd2;
  localparam logic [7:0] T_B    = 8'd3;
  localparam logic [7:0] T_C    = 8'd4;
  localparam logic [7:0] T_D    = 8'd5;
  localparam logic [7:0] T_DONE = 8'd6;

  typedef struct packed {
    logic        p;
    logic        v;
    logic        h;
    logic        fd;
    logic [7:0]  d;
    logic [7:0]  tag;
    logic [15:0] idx;
  } exp_t;

  logic       clk_25 = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pclk;
  logic       v_sync;
  logic       h_ref;
  logic [7:0] data_out;
  logic       frame_done;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycleNo  = 0;
  logic pclkExp  = 1'b0;

  // Hand-computed luma of line 0 then line 1 for an unscrolled frame
  logic [7:0] lumaBase [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};

  always #5 clk_25 = ~clk_25;

  vga_camera_emulator #(
    .H_ACTIVE(H_ACTIVE),
    .H_BLANK (H_BLANK),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_ACTIVE(V_ACTIVE),
    .V_FRONT (V_FRONT)
  ) dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .enable    (enable),
    .pclk      (pclk),
    .v_sync    (v_sync),
    .h_ref     (h_ref),
    .data_out  (data_out),
    .frame_done(frame_done)
  );

  function automatic string tagName(input logic [7:0] tag);
    case (tag)
      T_RST:   return "reset";
      T_IDLE:  return "idle";
      T_A:     return "frameA";
      T_B:     return "frameB_b2b";
      T_C:     return "frameC_cut";
      T_D:     return "frameD_after_reset";
      T_DONE:  return "frame_done_idle";
      default: return "unknown";
    endcase
  endfunction

  // Drive one clk_25 cycle of inputs and queue what the bus must show afterwards
  task automatic applyStimulus(input logic rstN, input logic en, input logic v, input logic h,
                               input logic [7:0] d, input logic fd, input logic [7:0] tag);
    exp_t e;
    reset_n = rstN;
    enable  = en;
    @(posedge clk_25);
    #2;
    pclkExp = rstN ? ~pclkExp : 1'b0;
    e.p   = pclkExp;
    e.v   = v;
    e.h   = h;
    e.fd  = fd;
    e.d   = d;
    e.tag = tag;
    e.idx = 16'(cycleNo);
    cycleNo++;
    expQ.push_back(e);
  endtask

  task automatic idleUntilTick(input logic en);
    while (pclkExp != 1'b1) begin
      applyStimulus(1'b1, en, 1'b0, 1'b0, 8'h00, 1'b0, T_IDLE);
    end
  endtask

  // k counts clk_25 cycles from the tick that starts the frame
  task automatic runFrame(input int f, input int stopK, input int dropK, input logic firstFd,
                          input logic [7:0] tag);
    for (int k = 0; k < stopK; k++) begin
      int t;
      int ln;
      int bx;
      logic v;
      logic h;
      logic [7:0] d;
      t = k / 2;
      v = (t < 10);
      h = 1'b0;
      d = 8'h00;
      if (t >= 20 && t < 40) begin
        ln = (t - 20) / 10;
        bx = (t - 20) % 10;
        if (bx < 8) begin
          h = 1'b1;
          d = (bx % 2 == 0) ? 8'h80 : lumaBase[ln * 4 + bx / 2] + 8'(SCROLL * f);
        end
      end
      applyStimulus(1'b1, logic'(k < dropK), v, h, d, (k == 0) ? firstFd : 1'b0, tag);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [11:0] act;
    logic [11:0] req;
    act = {pclk, v_sync, h_ref, frame_done, data_out};
    req = {e.p, e.v, e.h, e.fd, e.d};
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got pclk=%b v_sync=%b h_ref=%b frame_done=%b data=%h, want pclk=%b v_sync=%b h_ref=%b frame_done=%b data=%h",
               tagName(e.tag), e.idx, pclk, v_sync, h_ref, frame_done, data_out,
               e.p, e.v, e.h, e.fd, e.d);
    end
  endtask

  always @(negedge clk_25) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, T_RST);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, T_IDLE);

    idleUntilTick(1'b0);
    runFrame(0, 100, 1000, 1'b0, T_A);
    runFrame(1, 100, 60, 1'b1, T_B);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, T_DONE);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, T_IDLE);

    idleUntilTick(1'b0);
    runFrame(2, 47, 1000, 1'b0, T_C);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, T_RST);

    idleUntilTick(1'b1);
    runFrame(0, 100, 1, 1'b0, T_D);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, T_DONE);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, T_IDLE);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk_25);
      #1;
    end
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
